// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: shares one AXI4 master write channel (AW/W/B) between two
// single-beat write requesters, one outstanding transaction at a time.
//
// Parameters : ADDR_W, DATA_W, STRB_W (= DATA_W/8)
// Clock/reset: axi_aclk (rising edge), axi_aresetn (async, active low)
// Requester N (N=0,1):
//   reqN_valid/addr/data/strb in, reqN_ready out (combinational accept),
//   reqN_done out (one-cycle pulse on B completion), reqN_resp out (held BRESP)
// AXI master : m_axi_aw* (single-beat INCR), m_axi_w*, m_axi_b*; all registered
// Build option: define ARB_RR_EN for round-robin tie breaking; otherwise
//   req0 has fixed priority on ties.
module axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [STRB_W-1:0] req0_strb,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [1:0]        req0_resp,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [STRB_W-1:0] req1_strb,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [1:0]        req1_resp,

    input  logic              m_axi_awready,
    output logic              m_axi_awvalid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [1:0]        m_axi_awburst,
    output logic [3:0]        m_axi_awcache,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,

    input  logic              m_axi_wready,
    output logic              m_axi_wvalid,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,

    input  logic              m_axi_bvalid,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_bready
);

    localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    state_t state;
    logic   owner;
    logic   gnt0;
    logic   gnt1;
    logic   aw_left;
    logic   w_left;

    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AW_SIZE;
    assign m_axi_wlast   = m_axi_wvalid;

`ifdef ARB_RR_EN
    // last_gnt holds the previous winner; the other requester wins a tie.
    logic last_gnt;

    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_gnt);
        gnt1 = req1_valid & (~req0_valid | ~last_gnt);
    end
`else
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    // Gated by reset so no accept is offered while reset is held.
    assign req0_ready = axi_aresetn & (state == IDLE) & gnt0;
    assign req1_ready = axi_aresetn & (state == IDLE) & gnt1;

    // A channel is still owed if its valid stays up past this edge.
    assign aw_left = m_axi_awvalid & ~m_axi_awready;
    assign w_left  = m_axi_wvalid & ~m_axi_wready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state         <= IDLE;
            owner         <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            req0_done     <= 1'b0;
            req1_done     <= 1'b0;
            req0_resp     <= 2'b00;
            req1_resp     <= 2'b00;
`ifdef ARB_RR_EN
            last_gnt      <= 1'b1;
`endif
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        owner         <= gnt1;
                        m_axi_awaddr  <= gnt1 ? req1_addr : req0_addr;
                        m_axi_wdata   <= gnt1 ? req1_data : req0_data;
                        m_axi_wstrb   <= gnt1 ? req1_strb : req0_strb;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (!aw_left && !w_left) begin
                        m_axi_bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_resp <= m_axi_bresp;
                        end else begin
                            req0_done <= 1'b1;
                            req0_resp <= m_axi_bresp;
                        end
`ifdef ARB_RR_EN
                        last_gnt <= owner;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed timing cases plus randomized traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_axi_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
    logic [3:0]  req0_strb, req1_strb;
    logic        req0_ready, req1_ready, req0_done, req1_done;
    logic [1:0]  req0_resp, req1_resp;
    logic        awready, awvalid, wready, wvalid, wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp, awburst;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb, awcache;
    logic [7:0]  awlen;
    logic [2:0]  awsize;

    always #5 clk = ~clk;

    axi_wr_arbiter dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_strb(req0_strb),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_resp(req0_resp),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_strb(req1_strb),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_resp(req1_resp),
        .m_axi_awready(awready), .m_axi_awvalid(awvalid),
        .m_axi_awaddr(awaddr), .m_axi_awburst(awburst),
        .m_axi_awcache(awcache), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize),
        .m_axi_wready(wready), .m_axi_wvalid(wvalid),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one write in flight with outstanding
    // obligations (AW beat, W beat, B response) that are discharged by
    // the slave's handshakes.
    bit          m_busy, m_aw, m_w, m_b;
    int          m_own;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;
    bit          m_done[2];
    logic [1:0]  m_resp[2];
`ifdef ARB_RR_EN
    int          m_last;
`endif

    function automatic int pick(logic v0, logic v1);
        if (v0 && v1) begin
`ifdef ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_aw = 0; m_w = 0; m_b = 0; m_own = 0;
        m_addr = '0; m_data = '0; m_strb = '0;
        m_done[0] = 0; m_done[1] = 0;
        m_resp[0] = 2'b00; m_resp[1] = 2'b00;
`ifdef ARB_RR_EN
        m_last = 1;
`endif
    endtask

    task automatic compare();
        int p;
        p = pick(req0_valid, req1_valid);
        chk("req0_ready", 64'(req0_ready), 64'(rst_n && !m_busy && p == 0));
        chk("req1_ready", 64'(req1_ready), 64'(rst_n && !m_busy && p == 1));
        chk("awvalid", 64'(awvalid), 64'(m_aw));
        chk("wvalid", 64'(wvalid), 64'(m_w));
        chk("wlast", 64'(wlast), 64'(m_w));
        chk("bready", 64'(bready), 64'(m_b));
        chk("awaddr", 64'(awaddr), 64'(m_addr));
        chk("wdata", 64'(wdata), 64'(m_data));
        chk("wstrb", 64'(wstrb), 64'(m_strb));
        chk("req0_done", 64'(req0_done), 64'(m_done[0]));
        chk("req1_done", 64'(req1_done), 64'(m_done[1]));
        chk("req0_resp", 64'(req0_resp), 64'(m_resp[0]));
        chk("req1_resp", 64'(req1_resp), 64'(m_resp[1]));
    endtask

    task automatic step();
        int p;
        bit nd0, nd1;
        nd0 = 0; nd1 = 0;
        if (!m_busy) begin
            p = pick(req0_valid, req1_valid);
            if (p >= 0) begin
                m_busy = 1; m_aw = 1; m_w = 1; m_own = p;
                m_addr = (p == 1) ? req1_addr : req0_addr;
                m_data = (p == 1) ? req1_data : req0_data;
                m_strb = (p == 1) ? req1_strb : req0_strb;
            end
        end else if (m_b) begin
            if (bvalid) begin
                m_b = 0; m_busy = 0;
                m_resp[m_own] = bresp;
                if (m_own == 1) nd1 = 1; else nd0 = 1;
`ifdef ARB_RR_EN
                m_last = m_own;
`endif
            end
        end else begin
            if (awready) m_aw = 0;
            if (wready) m_w = 0;
            if (!m_aw && !m_w) m_b = 1;
        end
        m_done[0] = nd0;
        m_done[1] = nd1;
    endtask

    int obs_gnt[$];
    int obs_done[$];

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        compare();
        if (rst_n && req0_valid && req0_ready) obs_gnt.push_back(0);
        if (rst_n && req1_valid && req1_ready) obs_gnt.push_back(1);
        if (req0_done) obs_done.push_back(0);
        if (req1_done) obs_done.push_back(1);
        if (rst_n) step();
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic ng();
        @(negedge clk);
    endtask

    task automatic do_wr(int n, logic [1:0] br);
        logic got;
        nx();
        if (n == 1) req1_valid = 1; else req0_valid = 1;
        awready = 1; wready = 1; bvalid = 1; bresp = br;
        ng();
        chk("wr_ready", 64'(n == 1 ? req1_ready : req0_ready), 64'(1));
        nx();
        req0_valid = 0; req1_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            ng();
            got = (n == 1) ? req1_done : req0_done;
            if (!got) nx();
        end
        chk("wr_done_seen", 64'(got), 64'(1));
    endtask

    int exp_g[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req0_valid = 0; req1_valid = 0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        req0_strb = '0; req1_strb = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;

        // reset values
        ng();
        chk("rst_awvalid", 64'(awvalid), 64'(0));
        chk("rst_awaddr", 64'(awaddr), 64'(0));
        chk("rst_awburst", 64'(awburst), 64'(1));
        chk("rst_awcache", 64'(awcache), 64'(3));
        chk("rst_awlen", 64'(awlen), 64'(0));
        chk("rst_awsize", 64'(awsize), 64'(2));

        // single req0 write, slave fully ready
        nx();
        rst_n = 1; req0_valid = 1;
        req0_addr = 32'h10; req0_data = 32'hA5A5A5A5; req0_strb = 4'hF;
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        ng();
        chk("t1_rdy0", 64'(req0_ready), 64'(1));
        chk("t1_rdy1", 64'(req1_ready), 64'(0));
        nx(); req0_valid = 0;
        ng();
        chk("t1_awvalid", 64'(awvalid), 64'(1));
        chk("t1_wvalid", 64'(wvalid), 64'(1));
        chk("t1_awaddr", 64'(awaddr), 64'h10);
        chk("t1_wdata", 64'(wdata), 64'hA5A5A5A5);
        chk("t1_wstrb", 64'(wstrb), 64'hF);
        chk("t1_awlen", 64'(awlen), 64'(0));
        chk("t1_wlast", 64'(wlast), 64'(1));
        chk("t1_awsize", 64'(awsize), 64'(2));
        nx(); ng();
        chk("t1_bready", 64'(bready), 64'(1));
        chk("t1_awvalid_lo", 64'(awvalid), 64'(0));
        nx(); ng();
        chk("t1_done0", 64'(req0_done), 64'(1));
        chk("t1_resp0", 64'(req0_resp), 64'(0));
        chk("t1_bready_lo", 64'(bready), 64'(0));

        // tie arbitration over four writes, from a fresh reset
        nx(); rst_n = 0;
        nx(); nx(); rst_n = 1;
        obs_gnt.delete(); obs_done.delete();
        req0_valid = 1; req1_valid = 1;
        req0_addr = 32'h100; req1_addr = 32'h200;
        for (int i = 0; i < 60 && obs_done.size() < 4; i++) begin
            nx();
            if (obs_gnt.size() >= 4) begin
                req0_valid = 0; req1_valid = 0;
            end
        end
        req0_valid = 0; req1_valid = 0;
`ifdef ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        chk("t2_ngrants", 64'(obs_gnt.size()), 64'(4));
        chk("t2_ndones", 64'(obs_done.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", 64'(i < obs_gnt.size() ? obs_gnt[i] : -1),
                64'(exp_g[i]));
            chk("t2_done_owner", 64'(i < obs_done.size() ? obs_done[i] : -1),
                64'(exp_g[i]));
        end

        // AW first, W stalled until cycle 4
        nx();
        req0_valid = 1; req0_addr = 32'h20; req0_data = 32'h1234;
        awready = 1; wready = 0; bvalid = 0;
        ng(); chk("t3_rdy0", 64'(req0_ready), 64'(1));
        nx(); req0_valid = 0; req0_data = 32'hFFFF;
        ng(); chk("t3_c1_awv", 64'(awvalid), 64'(1));
        nx(); ng();
        chk("t3_c2_awv", 64'(awvalid), 64'(0));
        chk("t3_c2_wv", 64'(wvalid), 64'(1));
        chk("t3_c2_wdata", 64'(wdata), 64'h1234);
        nx(); ng();
        chk("t3_c3_wv", 64'(wvalid), 64'(1));
        chk("t3_c3_bready", 64'(bready), 64'(0));
        nx(); wready = 1;
        ng(); chk("t3_c4_wv", 64'(wvalid), 64'(1));
        nx(); bvalid = 1;
        ng();
        chk("t3_c5_wv", 64'(wvalid), 64'(0));
        chk("t3_c5_bready", 64'(bready), 64'(1));
        nx(); ng(); chk("t3_done0", 64'(req0_done), 64'(1));

        // W first, AW accepted at cycle 3
        nx();
        req1_valid = 1; req1_addr = 32'h30; req1_data = 32'h55;
        awready = 0; wready = 1; bvalid = 0;
        ng(); chk("t4_rdy1", 64'(req1_ready), 64'(1));
        nx(); req1_valid = 0; req1_addr = 32'hDEAD;
        ng(); chk("t4_c1_wv", 64'(wvalid), 64'(1));
        nx(); ng();
        chk("t4_c2_awv", 64'(awvalid), 64'(1));
        chk("t4_c2_wv", 64'(wvalid), 64'(0));
        chk("t4_c2_awaddr", 64'(awaddr), 64'h30);
        nx(); awready = 1;
        ng(); chk("t4_c3_bready", 64'(bready), 64'(0));
        nx(); bvalid = 1;
        ng();
        chk("t4_c4_awv", 64'(awvalid), 64'(0));
        chk("t4_c4_bready", 64'(bready), 64'(1));
        nx(); ng(); chk("t4_done1", 64'(req1_done), 64'(1));

        // error responses land on the owner only
        do_wr(0, 2'b01);
        chk("t5_resp0", 64'(req0_resp), 64'(1));
        do_wr(1, 2'b10);
        chk("t5_resp1", 64'(req1_resp), 64'(2));
        chk("t5_resp0_kept", 64'(req0_resp), 64'(1));

        // reset while waiting for B
        nx();
        req0_valid = 1; awready = 1; wready = 1; bvalid = 0;
        ng();
        nx(); req0_valid = 0;
        ng();
        nx(); ng();
        chk("t6_bready", 64'(bready), 64'(1));
        #2; rst_n = 0; req0_valid = 1;
        #1;
        chk("t6_bready_rst", 64'(bready), 64'(0));
        chk("t6_awv_rst", 64'(awvalid), 64'(0));
        chk("t6_wv_rst", 64'(wvalid), 64'(0));
        chk("t6_rdy_rst", 64'(req0_ready), 64'(0));
        chk("t6_resp0_rst", 64'(req0_resp), 64'(0));
        nx(); nx(); rst_n = 1; req0_valid = 0;
        do_wr(1, 2'b00);
        chk("t6_resp1", 64'(req1_resp), 64'(0));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            nx();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_addr = $urandom; req1_addr = $urandom;
            req0_data = $urandom; req1_data = $urandom;
            req0_strb = 4'($urandom); req1_strb = 4'($urandom);
            awready = ($urandom_range(0, 2) != 0);
            wready = ($urandom_range(0, 2) != 0);
            bvalid = ($urandom_range(0, 2) != 0);
            bresp = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 399) != 0);
        end
        nx();
        rst_n = 1;
        nx();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-requester write arbiter that shares one AXI4 master write channel (AW/W/B) between two single-beat write sources, such as the frame write sequencer and a register/config writer. It grants one requester at a time and drives a single-beat INCR burst with independent AW and W handshakes. It then waits for the B response and returns that response to the winning requester. It sits between the internal write sources and the interconnect's slave write port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STRB_W, 4, strobe width (DATA_W/8)
- axi_aclk  in  1  clock, all logic on rising edge
- axi_aresetn  in  1  asynchronous active-low reset
- reqN_valid (N=0,1)  in  1  requester N has a write pending
- reqN_addr  in  ADDR_W  write address, sampled on accept
- reqN_data  in  DATA_W  write data, sampled on accept
- reqN_strb  in  STRB_W  byte strobes, sampled on accept
- reqN_ready  out  1  combinational accept; transfer on reqN_valid & reqN_ready
- reqN_done  out  1  one-cycle pulse when the B response for N's write completes
- reqN_resp  out  2  BRESP captured with reqN_done, held until the next done for N
- m_axi_awready  in  1 / m_axi_awvalid  out  1 / m_axi_awaddr  out  ADDR_W
- m_axi_awburst  out  2  constant 2'b01
- m_axi_awcache  out  4  constant 4'b0011
- m_axi_awlen  out  8  constant 0
- m_axi_awsize  out  3  constant clog2(STRB_W)
- m_axi_wready  in  1 / m_axi_wvalid  out  1 / m_axi_wdata  out  DATA_W / m_axi_wstrb  out  STRB_W
- m_axi_wlast  out  1  equals m_axi_wvalid
- m_axi_bvalid  in  1 / m_axi_bresp  in  2 / m_axi_bready  out  1

## Operation
- States: IDLE, XFER, RESP.
- IDLE:
  - reqN_ready is high only for the granted requester, computed from the current reqN_valid values.
  - On accept: latch addr/data/strb into the AW/W output registers, record the owner, set awvalid=wvalid=1, go to XFER.
- XFER:
  - awvalid drops in the cycle after an AW handshake (awvalid&awready). wvalid drops in the cycle after a W handshake.
  - The two handshakes are independent and may occur in the same cycle or in either order.
  - Once both handshakes have completed, bready=1 and the state goes to RESP.
- RESP:
  - On bvalid&bready: bready=0, owner's reqN_done=1 for one cycle, reqN_resp<=bresp, last-grant register <= owner, go to IDLE.
- Grant with one valid requester: that requester wins.
- Grant with both valid: see Configuration.
- Only one transaction is outstanding at a time; no new AW is issued before B completes.
- Payload registers keep their values after the handshake; they change only on the next accept.
- Reset:
  - Asserting reset mid-transaction drops awvalid, wvalid, bready, reqN_done, reqN_ready and reqN_resp immediately.
  - FSM goes to IDLE and last-grant goes to 1. The interrupted write is abandoned, and the requester must reissue it.
- Reset values:
  - All valid/ready/done outputs 0; awaddr, wdata, wstrb and reqN_resp 0.
  - awburst, awcache, awlen and awsize hold their constants.

## Timing
- Cycle 0: accept, reqN_valid&reqN_ready.
- Cycle 1: awvalid=wvalid=1. If both readies are high, both handshakes complete here.
- Cycle 2: bready=1. If bvalid is high, B completes.
- Cycle 3: reqN_done=1, FSM in IDLE, a new accept is possible.
- Minimum spacing between accepts is 3 cycles.
- Each cycle of awready/wready/bvalid stall adds one cycle; there is no timeout.
- reqN_ready never depends on any m_axi_* input.
- All outputs are registered except reqN_ready.

## Configuration
- ARB_RR_EN defined: round-robin. On simultaneous requests the requester not recorded in last-grant wins. After reset req0 wins the first tie, then the winner alternates.
- ARB_RR_EN undefined: fixed priority, req0 always wins ties. The last-grant register is not implemented, and req1 can starve.

## Test plan
- req0 writes addr 0x10, data 0xA5A5A5A5, strb 0xF with all slave readies high -> AW/W handshake cycle 1; bready cycle 2; req0_done cycle 3 with resp 2'b00. Check awlen=0, wlast=1, awsize=2.
- Both requesters hold valid for 4 writes (ARB_RR_EN) -> grants 0,1,0,1; each done is pulsed for the correct owner. With the macro undefined -> grants 0,0,0,0.
- awready high at cycle 1, wready delayed to cycle 4 -> awvalid low from cycle 2; wvalid held until cycle 4; bready from cycle 5.
- wready at cycle 1, awready at cycle 3 -> W handshakes first; bready from cycle 4. Data/addr are stable while valid is high.
- Slave returns bresp=2'b10 for a req1 write -> req1_done pulse with req1_resp=2'b10; req0_resp unchanged.
- axi_aresetn asserted in RESP with bready=1 -> bready, awvalid and wvalid drop at once. After release the FSM is in IDLE, and a new req1 write completes normally.
